// File: rtl/truth_pkg.sv
// Shared types and default sizing for the truth-table sweep sequencer.
package truth_pkg;

    localparam int unsigned N_IN_DEF   = 3;
    localparam int unsigned SETTLE_DEF = 1;
    localparam int unsigned N_MINT     = 1 << N_IN_DEF;
    localparam int unsigned CNT_W      = $clog2(SETTLE_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage

// File: rtl/truth_table_sequencer_settle_counter.sv
// Settle down-counter: reloads on clr, counts down while en, hit at zero.
module settle_counter #(
    parameter int unsigned COUNT = 1,
    parameter int unsigned W     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam logic [W-1:0] LOAD = W'(COUNT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = LOAD;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all minterms into a combinational block, captures its truth table
// and grades it against an expected mask.
module truth_table_sequencer
    import truth_pkg::*;
#(
    parameter int unsigned N_IN   = N_IN_DEF,
    parameter int unsigned SETTLE = SETTLE_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   expected,
    input  logic                   dut_s,
    output logic [N_IN-1:0]        vec,
    output logic                   vec_valid,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic                   pass,
    output logic [N_IN:0]          mismatches,
    output logic [N_IN-1:0]        first_fail
);

    localparam int unsigned NM = 1 << N_IN;
    localparam int unsigned IW = N_IN + 1;
    localparam int unsigned CW = $clog2(SETTLE + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            vec_valid_q, vec_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [NM-1:0]   table_q, table_d;
    logic            pass_q, pass_d;
    logic [IW-1:0]   mism_q, mism_d;
    logic [N_IN-1:0] ff_q, ff_d;

    logic            hit;
    logic [NM-1:0]   diff_c;
    logic [IW-1:0]   mism_c;
    logic [N_IN-1:0] ff_c;

    // Counter is held at its reload value everywhere except DRIVE.
    settle_counter #(
        .COUNT (SETTLE),
        .W     (CW)
    ) u_settle (
        .clk   (clk),
        .reset (reset),
        .clr   (state_q != DRIVE),
        .en    (state_q == DRIVE),
        .hit   (hit)
    );

    // Grading: mismatch vector, popcount and lowest failing minterm.
    always_comb begin
        diff_c = table_q ^ expected;
        mism_c = '0;
        ff_c   = '0;
        for (int k = int'(NM) - 1; k >= 0; k--) begin
            if (diff_c[k]) begin
                ff_c = N_IN'(k);
            end
        end
        for (int k = 0; k < int'(NM); k++) begin
            mism_c = mism_c + IW'(diff_c[k]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        table_d = table_q;
        pass_d  = pass_q;
        mism_d  = mism_q;
        ff_d    = ff_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    vec_d   = '0;
                    table_d = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (hit) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[idx_q[N_IN-1:0]] = dut_s;
                // Terminal test on the wide index so vec never needs to wrap.
                if (idx_q == IW'(NM - 1)) begin
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    vec_d   = N_IN'(idx_q + IW'(1));
                    state_d = DRIVE;
                end
            end
            FINISH: begin
                pass_d  = (diff_c == '0);
                mism_d  = mism_c;
                ff_d    = ff_c;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        vec_valid_d = (state_d == DRIVE) || (state_d == SAMPLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            table_q     <= '0;
            pass_q      <= 1'b0;
            mism_q      <= '0;
            ff_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            table_q     <= table_d;
            pass_q      <= pass_d;
            mism_q      <= mism_d;
            ff_q        <= ff_d;
        end
    end

    assign vec        = vec_q;
    assign vec_valid  = vec_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign table_out  = table_q;
    assign pass       = pass_q;
    assign mismatches = mism_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: scoreboard on the SETTLE=1 instance plus a
// sequence/latency check on a SETTLE=3 instance.
module tb_truth_table_sequencer;

    localparam int S_A  = 1;
    localparam int S_B  = 3;
    localparam int SPAN = 8 * (S_A + 1);

    typedef struct packed {
        logic [7:0] tab;
        logic       pass;
        logic [3:0] mism;
        logic [2:0] ff;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       dut_s;
    logic [2:0] vec;
    logic       vec_valid, busy, done, pass;
    logic [7:0] table_out;
    logic [3:0] mismatches;
    logic [2:0] first_fail;

    logic       start_b = 1'b0;
    logic       dut_s_b;
    logic [2:0] vec_b;
    logic       vec_valid_b, busy_b, done_b, pass_b;
    logic [7:0] table_out_b;
    logic [3:0] mismatches_b;
    logic [2:0] first_fail_b;

    int         mode = 0;
    logic [7:0] rtab = 8'h00;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         launch_cnt = 0;
    int         launch_cyc = 0;
    int         last_done_cyc = 0;
    sb_t        q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Boolean block under sweep: x is vec[2], z is vec[0].
    function automatic logic ref_bit(int m, logic [7:0] rt, logic [2:0] k);
        logic x, y, z;
        x = k[2];
        y = k[1];
        z = k[0];
        case (m)
            0:       return !(x || !y) && !z;
            1:       return 1'b1;
            2:       return 1'b0;
            default: return rt[k];
        endcase
    endfunction

    function automatic sb_t predict(int m, logic [7:0] rt, logic [7:0] ex);
        sb_t r;
        int  cnt = 0;
        int  first = -1;
        r.tab = 8'h00;
        for (int k = 0; k < 8; k++) begin
            r.tab[k] = ref_bit(m, rt, 3'(k));
            if (r.tab[k] != ex[k]) begin
                cnt++;
                if (first < 0) first = k;
            end
        end
        r.pass = (cnt == 0);
        r.mism = 4'(cnt);
        r.ff   = (first < 0) ? 3'd0 : 3'(first);
        return r;
    endfunction

    always_comb dut_s   = ref_bit(mode, rtab, vec);
    always_comb dut_s_b = ref_bit(0, 8'h00, vec_b);

    truth_table_sequencer #(.N_IN(3), .SETTLE(S_A)) u_dut (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .dut_s(dut_s),
        .vec(vec), .vec_valid(vec_valid), .busy(busy), .done(done),
        .table_out(table_out), .pass(pass), .mismatches(mismatches), .first_fail(first_fail)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE(S_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .expected(8'h04), .dut_s(dut_s_b),
        .vec(vec_b), .vec_valid(vec_valid_b), .busy(busy_b), .done(done_b),
        .table_out(table_out_b), .pass(pass_b), .mismatches(mismatches_b), .first_fail(first_fail_b)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: vec sequence, done latency/width, scoreboard pop and grading.
    initial begin
        logic busy_prev = 1'b0;
        logic done_prev = 1'b0;
        logic pend = 1'b0;
        sb_t  cur = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy_prev = 1'b0;
                done_prev = 1'b0;
                pend      = 1'b0;
            end else begin
                if (pend) begin
                    chk("pass", 32'(pass), 32'(cur.pass));
                    chk("mismatches", 32'(mismatches), 32'(cur.mism));
                    chk("first_fail", 32'(first_fail), 32'(cur.ff));
                    pend = 1'b0;
                end
                if (busy && !busy_prev) begin
                    launch_cyc = cyc;
                    launch_cnt++;
                end
                if (busy && (cyc - launch_cyc) < SPAN) begin
                    chk("vec_seq", 32'(vec), 32'((cyc - launch_cyc) / (S_A + 1)));
                    chk("vec_valid_live", 32'(vec_valid), 32'd1);
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                    chk("done_latency", 32'(cyc - launch_cyc + 1), 32'(SPAN + 1));
                    chk("done_width", 32'(done_prev), 32'd0);
                    chk("vec_valid_at_done", 32'(vec_valid), 32'd0);
                    chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                    if (q.size() > 0) begin
                        cur = q.pop_front();
                        chk("table_out", 32'(table_out), 32'(cur.tab));
                        pend = 1'b1;
                    end
                end
                busy_prev = busy;
                done_prev = done;
            end
        end
    end

    task automatic wait_dones(int target, int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_arrived", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic sweep(int m, logic [7:0] rt, logic [7:0] ex);
        int base = done_cnt;
        mode = m;
        rtab = rt;
        expected = ex;
        q.push_back(predict(m, rt, ex));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // expected is only graded at the end of the sweep
        repeat (6) begin
            @(negedge clk);
            expected = 8'($urandom);
        end
        expected = ex;
        wait_dones(base + 1, 60);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rt, ex;
        int n, base, lb, tstart, j;

        repeat (3) @(negedge clk);
        chk("rst_vec", 32'(vec), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_table", 32'(table_out), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_mism", 32'(mismatches), 32'd0);
        chk("rst_ff", 32'(first_fail), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        sweep(0, 8'h00, 8'h04);
        chk("vec_hold", 32'(vec), 32'd7);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_vec_valid", 32'(vec_valid), 32'd0);
        sweep(0, 8'h00, 8'h06);
        sweep(1, 8'h00, 8'hFF);
        sweep(2, 8'h00, 8'hFF);
        repeat (6) begin
            rt = 8'($urandom);
            ex = ($urandom_range(0, 2) == 0) ? rt : 8'($urandom);
            sweep(3, rt, ex);
        end

        // Reset mid-sweep at vec=5
        base = done_cnt;
        mode = 0;
        expected = 8'h04;
        q.push_back(predict(0, 8'h00, 8'h04));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(vec == 3'd5 && vec_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec5", 32'(vec), 32'd5);
        reset = 1'b1;
        #1;
        chk("arst_vec", 32'(vec), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_table", 32'(table_out), 32'd0);
        chk("arst_vec_valid", 32'(vec_valid), 32'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(base));
        sweep(0, 8'h00, 8'h04);

        // start held through a sweep and its done cycle
        base = done_cnt;
        lb = launch_cnt;
        mode = 0;
        expected = 8'h04;
        q.push_back(predict(0, 8'h00, 8'h04));
        q.push_back(predict(0, 8'h00, 8'h04));
        start = 1'b1;
        n = 0;
        while (launch_cnt < lb + 2 && n < 80) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("second_launch", 32'(launch_cnt), 32'(lb + 2));
        chk("relaunch_gap", 32'(launch_cyc - last_done_cyc), 32'd2);
        wait_dones(base + 2, 60);
        repeat (25) @(negedge clk);
        chk("one_done_per_sweep", 32'(done_cnt), 32'(base + 2));

        // SETTLE=3 instance: each minterm held 4 cycles, done at cycle 33
        tstart = cyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 60) begin
            j = cyc - tstart;
            if (j >= 1 && j <= 32) begin
                chk("b_vec_seq", 32'(vec_b), 32'((j - 1) / (S_B + 1)));
                chk("b_vec_valid", 32'(vec_valid_b), 32'd1);
            end
            @(negedge clk);
            n++;
        end
        chk("b_done_seen", 32'(done_b), 32'd1);
        chk("b_latency", 32'(cyc - tstart), 32'(8 * (S_B + 1) + 1));
        chk("b_table", 32'(table_out_b), 32'h04);
        @(negedge clk);
        chk("b_pass", 32'(pass_b), 32'd1);
        chk("b_mism", 32'(mismatches_b), 32'd0);
        chk("b_ff", 32'(first_fail_b), 32'd0);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
